// File: rtl/seg_scan.sv
// Six-digit multiplexed 7-segment scanner with a per-frame input snapshot,
// inter-digit blanking, BCD decode, blinking separator points and leading-zero blanking.
module seg_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int ACTIVE_LOW   = 1,
  parameter int LZB          = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hour_10,
  input  logic [3:0] hour1,
  input  logic [3:0] min_10,
  input  logic [3:0] min1,
  input  logic [3:0] sec_10,
  input  logic [3:0] sec1,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] dig_sel,
  output logic       frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [13:0]   POL       = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [3:0]    snap [6];
  logic [3:0]    cur;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [5:0]    dig_n;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // Slot index 0 is the rightmost digit (sec1), slot 5 the leftmost (hour_10).
  always_comb begin
    cur = '0;
    case (idx)
      3'd0:    cur = snap[0];
      3'd1:    cur = snap[1];
      3'd2:    cur = snap[2];
      3'd3:    cur = snap[3];
      3'd4:    cur = snap[4];
      3'd5:    cur = snap[5];
      default: cur = '0;
    endcase
  end

  always_comb begin
    seg_n = '0;
    dp_n  = 1'b0;
    dig_n = '0;
    if (cnt >= BLANK_END) begin
      dig_n = 6'b000001 << idx;
      seg_n = decode(cur);
      if (LZB != 0 && idx == 3'd5 && cur == 4'd0)
        seg_n = '0;
      dp_n = (idx == 3'd2 || idx == 3'd4) && !snap[0][0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
      for (int unsigned i = 0; i < 6; i++)
        snap[i] <= '0;
      {seg, dp, dig_sel} <= POL;
    end else begin
      frame_done <= (cnt == CNT_LAST) && (idx == 3'd5);
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == 3'd5) ? '0 : idx + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      // One coherent capture per frame, taken while slot 0 is still blanked.
      if (cnt == '0 && idx == '0) begin
        snap[0] <= sec1;
        snap[1] <= sec_10;
        snap[2] <= min1;
        snap[3] <= min_10;
        snap[4] <= hour1;
        snap[5] <= hour_10;
      end
      {seg, dp, dig_sel} <= {seg_n, dp_n, dig_n} ^ POL;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: three instances (active-high/no LZB, active-high/LZB,
// active-low/LZB) share stimulus; expected outputs are queued per cycle and checked by a monitor.
module tb_seg_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] hour_10, hour1, min_10, min1, sec_10, sec1;
  logic [6:0] seg0, seg1, seg2;
  logic       dp0, dp1, dp2;
  logic [5:0] dig0, dig1, dig2;
  logic       fd0, fd1, fd2;

  always #5 clk = ~clk;

  seg_scan #(.SCAN_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(0), .LZB(0)) u0 (
    .clk(clk), .rst(rst), .hour_10(hour_10), .hour1(hour1), .min_10(min_10),
    .min1(min1), .sec_10(sec_10), .sec1(sec1),
    .seg(seg0), .dp(dp0), .dig_sel(dig0), .frame_done(fd0));

  seg_scan #(.SCAN_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(0), .LZB(1)) u1 (
    .clk(clk), .rst(rst), .hour_10(hour_10), .hour1(hour1), .min_10(min_10),
    .min1(min1), .sec_10(sec_10), .sec1(sec1),
    .seg(seg1), .dp(dp1), .dig_sel(dig1), .frame_done(fd1));

  seg_scan #(.SCAN_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1), .LZB(1)) u2 (
    .clk(clk), .rst(rst), .hour_10(hour_10), .hour1(hour1), .min_10(min_10),
    .min1(min1), .sec_10(sec_10), .sec1(sec1),
    .seg(seg2), .dp(dp2), .dig_sel(dig2), .frame_done(fd2));

  typedef struct {
    int         at;
    int         dut;
    int         tag;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] dig;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   r0, r2;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle, pop all expectations due now and compare.
  always @(negedge clk) begin : mon
    exp_t       e;
    logic [6:0] a_seg;
    logic       a_dp;
    logic [5:0] a_dig;
    logic       a_fd;
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      vectors++;
      case (e.dut)
        0:       begin a_seg = seg0; a_dp = dp0; a_dig = dig0; a_fd = fd0; end
        1:       begin a_seg = seg1; a_dp = dp1; a_dig = dig1; a_fd = fd1; end
        default: begin a_seg = seg2; a_dp = dp2; a_dig = dig2; a_fd = fd2; end
      endcase
      if (e.at != cyc || {a_seg, a_dp, a_dig, a_fd} !== {e.seg, e.dp, e.dig, e.fd}) begin
        miscompares++;
        $display("FAIL u%0d tag %0d cyc %0d (due %0d): got seg=%h dp=%b dig=%h fd=%b, want seg=%h dp=%b dig=%h fd=%b",
                 e.dut, e.tag, cyc, e.at, a_seg, a_dp, a_dig, a_fd, e.seg, e.dp, e.dig, e.fd);
      end
    end
  end

  task automatic push(input int at, input int dut, input int tag, input logic [6:0] s,
                      input logic d, input logic [5:0] g, input logic f);
    exp_t e;
    e.at = at; e.dut = dut; e.tag = tag; e.seg = s; e.dp = d; e.dig = g; e.fd = f;
    q.push_back(e);
  endtask

  // All three instances fully off (u2 pins are inverted).
  task automatic push_off(input int at, input int tag);
    push(at, 0, tag, 7'h00, 1'b0, 6'h00, 1'b0);
    push(at, 1, tag, 7'h00, 1'b0, 6'h00, 1'b0);
    push(at, 2, tag, 7'h7F, 1'b1, 6'h3F, 1'b0);
  endtask

  // s0: logical seg for the no-LZB instance, s1: for the LZB instances; index = slot.
  task automatic push_frame(input int base, input int tag0,
                            input logic [5:0][6:0] s0, input logic [5:0][6:0] s1,
                            input logic [5:0] dpm, input int nslot, input int lastk);
    int at, tag, kmax;
    logic f;
    logic [5:0] dig;
    for (int slot = 0; slot < nslot; slot++) begin
      kmax = (slot == nslot - 1) ? lastk : 8;
      dig  = 6'b000001 << slot;
      for (int k = 1; k <= kmax; k++) begin
        at  = base + slot * 8 + k;
        tag = tag0 + slot * 10 + k;
        f   = (slot == 5 && k == 8);
        if (k <= 2) begin
          push(at, 0, tag, 7'h00, 1'b0, 6'h00, f);
          push(at, 1, tag, 7'h00, 1'b0, 6'h00, f);
          push(at, 2, tag, 7'h7F, 1'b1, 6'h3F, f);
        end else begin
          push(at, 0, tag, s0[slot], dpm[slot], dig, f);
          push(at, 1, tag, s1[slot], dpm[slot], dig, f);
          push(at, 2, tag, ~s1[slot], ~dpm[slot], ~dig, f);
        end
      end
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic set_time(input logic [3:0] h10, h1, m10, m1, s10, s1);
    hour_10 = h10; hour1 = h1; min_10 = m10; min1 = m1; sec_10 = s10; sec1 = s1;
  endtask

  localparam logic [5:0][6:0] F1 = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D}; // 12:34:56
  localparam logic [5:0][6:0] F2 = {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h6F}; // 23:59:59
  localparam logic [5:0][6:0] F3A = {7'h3F, 7'h07, 7'h66, 7'h7F, 7'h5B, 7'h40}; // 07:48:2C
  localparam logic [5:0][6:0] F3B = {7'h00, 7'h07, 7'h66, 7'h7F, 7'h5B, 7'h40};
  localparam logic [5:0][6:0] F5A = {7'h3F, 7'h6F, 7'h66, 7'h06, 7'h4F, 7'h07}; // 09:41:37
  localparam logic [5:0][6:0] F5B = {7'h00, 7'h6F, 7'h66, 7'h06, 7'h4F, 7'h07};

  initial begin
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 20; i++) push_off(cyc + i, i);
    repeat (20) @(negedge clk);

    rst = 1'b1;
    r0 = cyc;
    push_frame(r0,       100, F1,  F1,  6'b010100, 6, 8);
    push_frame(r0 + 48,  200, F2,  F2,  6'b000000, 6, 8);
    push_frame(r0 + 96,  300, F3A, F3B, 6'b010100, 6, 8);
    push_frame(r0 + 144, 400, F3A, F3B, 6'b010100, 4, 4);

    wait_until(r0 + 27);  // mid slot 3: must not leak into slots 4-5
    set_time(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9);
    wait_until(r0 + 60);  // after frame-2 capture
    set_time(4'd0, 4'd7, 4'd4, 4'd8, 4'd2, 4'hC);

    wait_until(r0 + 172);
    @(posedge clk);
    #1 rst = 1'b0;        // slot 3 cycle 5 of frame 4
    for (int i = 0; i < 3; i++) push_off(cyc + i, 900 + i);
    set_time(4'd0, 4'd9, 4'd4, 4'd1, 4'd3, 4'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    r2 = cyc;
    push_frame(r2, 500, F5A, F5B, 6'b000000, 6, 8);

    wait_until(r2 + 52);
    if (q.size() != 0) begin
      $display("FAIL leftover: got %0d unchecked expectations, want 0", q.size());
      miscompares += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
